mem_net_inject_arbiter: RTL and testbench

Shares one on-chip memory network router local injection port among NUM_REQ requesters (cores plus the external-memory channel).
- Round-robin arbitration at packet granularity, with wormhole locking so multi-flit wide (SRF) packets are never interleaved.
- Credit-based flow control toward the router input FIFO.
- Registered output flit stage.

---
 rtl/mem_net_inject_arbiter_pkg.sv | 23 ++
 rtl/mem_net_inject_arbiter_rr_arbiter.sv | 40 ++++
 rtl/mem_net_inject_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_net_inject_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_net_inject_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_net_inject_arbiter_pkg
// Shared types and constants for the on-chip memory network.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_net_inject_arbiter_pkg;

  // ---------------- Network section ----------------
  // Depth of a router input FIFO; one credit per slot.
  localparam int BUFFER_DEPTH    = 4;
  localparam int MEM_NET_CREDITS = BUFFER_DEPTH;

  // Injection-port arbiter: free to pick a new packet, or wormhole-locked.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_net_inject_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N. Returns a one-hot grant and its encoded index.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_net_inject_arbiter.sv
// ---------------------------------------------------------------------------
// mem_net_inject_arbiter
// Shares one router local injection port among NUM_REQ requesters with
// packet-granular round-robin, wormhole locking, credit flow control and a
// registered output flit stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_net_inject_arbiter
  import mem_net_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FLIT_WIDTH = 64,
  parameter int CREDITS    = MEM_NET_CREDITS,
  parameter int MAX_FLITS  = 4,
  parameter int IW         = $clog2(NUM_REQ),
  parameter int CW         = $clog2(CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic                          out_last,
  output logic [IW-1:0]                 out_src,
  input  logic                          credit_return,
  output logic [CW-1:0]                 credit_cnt,
  output logic                          locked,
  output logic [1:0]                    err
);

  localparam int FW = $clog2(MAX_FLITS + 2);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [FW-1:0] FC_MAX   = FW'(MAX_FLITS);
  localparam logic [FW-1:0] FC_SAT   = FW'(MAX_FLITS + 1);

  arb_state_t              state;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           owner;
  logic [FW-1:0]           flit_cnt;
  logic                    err_credit;
  logic                    err_len;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IW-1:0]           arb_idx;
  logic [NUM_REQ-1:0]      ready;
  logic [IW-1:0]           sel;
  logic [IW-1:0]           nxt_ptr;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic                    sel_last;
  logic                    hs;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Ready: arbiter winner when idle, owner only when locked, nothing without credit.
  always_comb begin
    ready = '0;
    sel   = (state == ARB_IDLE) ? arb_idx : owner;
    if (credit_cnt != '0) begin
      if (state == ARB_IDLE) ready = arb_grant;
      else                   ready[owner] = 1'b1;
    end
  end

  assign req_ready = ready;
  assign hs        = |(req_valid & ready);
  assign sel_flit  = req_flit[sel*FLIT_WIDTH +: FLIT_WIDTH];
  assign sel_last  = req_last[sel];
  assign nxt_ptr   = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
  assign locked    = (state == ARB_LOCKED);
  assign err       = {err_len, err_credit};

  // Credit counter: consumed on handshake, refilled by router, saturating with overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CRED_MAX;
      err_credit <= 1'b0;
    end else if (hs && !credit_return) begin
      credit_cnt <= credit_cnt - CW'(1);
    end else if (!hs && credit_return) begin
      if (credit_cnt == CRED_MAX) err_credit <= 1'b1;
      else                        credit_cnt <= credit_cnt + CW'(1);
    end
  end

  // Lock FSM: a multi-flit packet holds the port until its last flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      flit_cnt <= '0;
      err_len  <= 1'b0;
    end else if (hs) begin
      case (state)
        ARB_IDLE: begin
          if (sel_last) begin
            rr_ptr <= nxt_ptr;
          end else begin
            state    <= ARB_LOCKED;
            owner    <= sel;
            flit_cnt <= FW'(1);
          end
        end
        ARB_LOCKED: begin
          if (flit_cnt >= FC_MAX) err_len <= 1'b1;
          if (flit_cnt != FC_SAT) flit_cnt <= flit_cnt + FW'(1);
          if (sel_last) begin
            state    <= ARB_IDLE;
            rr_ptr   <= nxt_ptr;
            flit_cnt <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Output stage: the accepted flit appears one cycle after its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      out_valid <= hs;
      if (hs) begin
        out_flit <= sel_flit;
        out_last <= sel_last;
        out_src  <= sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_net_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_net_inject_arbiter
// Directed scenarios plus randomized traffic against a behavioural model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_net_inject_arbiter;

  localparam int N   = 4;
  localparam int FWD = 64;
  localparam int CR  = 4;
  localparam int MF  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*FWD-1:0] req_flit = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [FWD-1:0]  out_flit;
  logic            out_last;
  logic [1:0]      out_src;
  logic            credit_return = 1'b0;
  logic [2:0]      credit_cnt;
  logic            locked;
  logic [1:0]      err;

  mem_net_inject_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_flit(out_flit), .out_last(out_last), .out_src(out_src),
    .credit_return(credit_return), .credit_cnt(credit_cnt),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int          m_cred;
  int          m_ptr;
  int          m_own;      // -1 when no packet is in progress
  int          m_cnt;
  bit [1:0]    m_err;
  bit          e_valid;
  logic [63:0] e_flit;
  bit          e_last;
  int          e_src;
  int          last_win;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    if (m_cred == 0) return r;
    if (m_own >= 0) begin
      r[m_own] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) begin
        r[(m_ptr + k) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_cred = CR; m_ptr = 0; m_own = -1; m_cnt = 0; m_err = '0; e_valid = 0;
  endfunction

  // One clock cycle: inputs are driven before the call (at a negedge).
  task automatic step();
    logic [N-1:0] er;
    logic [63:0]  wflit;
    bit           wlast;
    bit           cr;
    int           win;
    #1;
    er = model_ready(req_valid);
    check("req_ready", 64'(req_ready), 64'(er));
    win = -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && er[i]) win = i;
    wflit = (win >= 0) ? req_flit[win*FWD +: FWD] : '0;
    wlast = (win >= 0) ? req_last[win] : 1'b0;
    cr    = credit_return;
    @(posedge clk); #1;
    if (win >= 0 && !cr) m_cred--;
    else if (win < 0 && cr) begin
      if (m_cred == CR) m_err[0] = 1'b1;
      else m_cred++;
    end
    e_valid = (win >= 0);
    if (win >= 0) begin
      e_flit = wflit; e_last = wlast; e_src = win;
      if (m_own < 0) begin
        if (wlast) m_ptr = (win + 1) % N;
        else begin m_own = win; m_cnt = 1; end
      end else begin
        m_cnt++;
        if (m_cnt > MF) m_err[1] = 1'b1;
        if (wlast) begin m_own = -1; m_ptr = (win + 1) % N; end
      end
    end
    last_win = win;
    check("out_valid", 64'(out_valid), 64'(e_valid));
    if (e_valid) begin
      check("out_flit", out_flit, e_flit);
      check("out_last", 64'(out_last), 64'(e_last));
      check("out_src", 64'(out_src), 64'(e_src));
    end
    check("credit_cnt", 64'(credit_cnt), 64'(m_cred));
    check("locked", 64'(locked), 64'(m_own >= 0));
    check("err", 64'(err), 64'(m_err));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", out_flit, 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_credit", 64'(credit_cnt), 64'd4);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_flits();
    for (int i = 0; i < N; i++) req_flit[i*FWD +: FWD] = {$urandom, $urandom};
  endtask

  int cnt;
  int len[N];
  int pos[N];

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single-flit fairness
    req_valid = 4'b1111; req_last = 4'b1111; credit_return = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_flits(); step();
      check("fair_src", 64'(out_src), 64'(k % 4));
      check("fair_cred", 64'(credit_cnt), 64'd4);
    end

    // Wormhole lock
    req_valid = '0; credit_return = 1'b0; step();
    do_reset();
    credit_return = 1'b1; req_last = 4'b0101;
    req_valid = 4'b0010; rand_flits(); step();
    check("worm_locked1", 64'(locked), 64'd1);
    req_valid = 4'b0111; rand_flits(); step();
    req_valid = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      rand_flits(); step();
      check("worm_hold_valid", 64'(out_valid), 64'd0);
      check("worm_hold_locked", 64'(locked), 64'd1);
    end
    req_valid = 4'b0111; rand_flits(); step();
    req_last = 4'b0111; rand_flits(); step();
    check("worm_last_src", 64'(out_src), 64'd1);
    check("worm_unlocked", 64'(locked), 64'd0);
    req_valid = 4'b0101; rand_flits(); step();
    check("worm_next_src", 64'(out_src), 64'd2);

    // Credit exhaustion
    do_reset();
    req_valid = 4'b0001; req_last = 4'b1111; credit_return = 1'b0; cnt = 0;
    for (int k = 0; k < 6; k++) begin rand_flits(); step(); if (out_valid) cnt++; end
    check("exhaust_count", 64'(cnt), 64'd4);
    #1; check("exhaust_ready", 64'(req_ready), 64'd0);
    credit_return = 1'b1; cnt = 0; step(); if (out_valid) cnt++;
    credit_return = 1'b0;
    for (int k = 0; k < 3; k++) begin rand_flits(); step(); if (out_valid) cnt++; end
    check("refill_count", 64'(cnt), 64'd1);

    // Simultaneous handshake and credit return
    do_reset();
    req_valid = 4'b0001; credit_return = 1'b0;
    step(); step();
    check("sim_pre", 64'(credit_cnt), 64'd2);
    credit_return = 1'b1; rand_flits(); step();
    check("sim_post", 64'(credit_cnt), 64'd2);
    check("sim_valid", 64'(out_valid), 64'd1);

    // Errors
    do_reset();
    req_valid = '0; credit_return = 1'b1; step();
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_cred", 64'(credit_cnt), 64'd4);
    req_valid = 4'b0010; req_last = '0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_last = 4'b0010;
      rand_flits(); step();
      if (k == 3) check("len_err_pre", 64'(err), 64'd1);
    end
    check("len_err", 64'(err), 64'd3);
    check("len_fwd", 64'(out_valid), 64'd1);
    check("len_fwd_last", 64'(out_last), 64'd1);
    req_valid = '0; credit_return = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("err_sticky", 64'(err), 64'd3);

    // Reset mid-packet
    do_reset();
    credit_return = 1'b1; req_valid = 4'b1000; req_last = '0;
    rand_flits(); step(); rand_flits(); step();
    check("mid_locked", 64'(locked), 64'd1);
    do_reset();
    check("mid_rst_locked", 64'(locked), 64'd0);
    check("mid_rst_cred", 64'(credit_cnt), 64'd4);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    req_valid = 4'b1111; req_last = 4'b1111; rand_flits(); step();
    check("mid_first_src", 64'(out_src), 64'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) begin len[i] = $urandom_range(1, MF); pos[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        req_valid = '0;
        do_reset();
        for (int i = 0; i < N; i++) begin len[i] = $urandom_range(1, MF); pos[i] = 0; end
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = (pos[i] == len[i] - 1);
      end
      credit_return = (m_cred < CR) && ($urandom_range(0, 2) != 0);
      rand_flits();
      step();
      if (last_win >= 0) begin
        if (pos[last_win] == len[last_win] - 1) begin
          pos[last_win] = 0; len[last_win] = $urandom_range(1, MF);
        end else pos[last_win]++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
